pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the fetch stage; the next generation of the single-register PC. Holds the fetch PC and advances it by a fixed step when fetch accepts, supports stall, resolved-branch redirect and exception redirect, and keeps a return-address stack (RAS) so returns are redirected without waiting for execute. Sits between the branch/exception logic and instruction memory.

## Interface
- WIDTH, 64, PC width in bits
- STEP, 4, sequential increment in bytes
- RESET_VEC, 0, PC value on reset
- EXC_VEC, 'h100, exception handler address
- RAS_DEPTH, 8, RAS entries; power of two, ≥2
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_ready  in  1  fetch consumed pc_out this cycle; permits sequential advance
- redirect_valid  in  1  resolved branch/jump redirect
- redirect_target  in  WIDTH  redirect address
- exc_req  in  1  exception redirect to EXC_VEC
- call_push  in  1  push call_link onto RAS
- call_link  in  WIDTH  return address to push
- ret_pop  in  1  predicted return: redirect to RAS top and pop
- pc_out  out  WIDTH  current fetch PC
- ras_count  out  $clog2(RAS_DEPTH)+1  valid entries
- ras_empty  out  1  ras_count==0
- ras_full  out  1  ras_count==RAS_DEPTH
- ras_underflow  out  1  one-cycle pulse: ret_pop honoured attempt on empty RAS

## Operation
- Next-PC priority, evaluated each cycle: exc_req → EXC_VEC; else redirect_valid → redirect_target; else ret_pop and RAS non-empty → RAS top; else fetch_ready → pc_out+STEP; else hold.
- exc_req, redirect_valid and ret_pop act regardless of fetch_ready.
- Sequential add is modulo 2^WIDTH: pc_out = 2^WIDTH−STEP advances to 0.
- RAS is circular: top pointer plus count.
  - Push: top pointer increments mod RAS_DEPTH, entry written; count increments, saturates at RAS_DEPTH (oldest overwritten when full).
  - Pop (only when not masked by exc_req/redirect_valid): target = current top; pointer decrements; count decrements.
  - Push and pop same cycle: target = old top; top entry overwritten with call_link; count unchanged.
  - ret_pop on empty, unmasked: no redirect, PC follows fetch_ready/hold; ras_underflow pulses; a concurrent push still occurs (count → 1).
  - ret_pop masked by higher-priority redirect: no pop, no underflow.
- exc_req flushes RAS: count → 0; concurrent call_push dropped.
- call_push honoured whenever exc_req is low, independent of fetch_ready and redirect_valid.

## Timing
- All outputs registered; every effect visible the cycle after the causing edge (1-cycle latency). No combinational input→output path.
- Reset assertion immediately (asynchronously) forces pc_out=RESET_VEC, ras_count=0, ras_underflow=0, pointer=0; RAS storage not cleared. Deassertion mid-operation: first edge after release evaluates normally; requests during reset are lost.
- ras_empty/ras_full derived from registered count.

## Structure
- Package pc_gen_pkg: default constants (PC_WIDTH_DEF, PC_STEP_DEF, RESET_VEC_DEF, EXC_VEC_DEF) and next-PC source enum (SRC_EXC, SRC_REDIR, SRC_RAS, SRC_SEQ, SRC_HOLD).
- Sub-module ras_stack: circular storage, pointer, count, push/pop/flush, top output. pc_gen holds the PC register and priority mux.

## Test plan
- Reset low then high, fetch_ready=1 for 3 cycles → pc_out 0, 4, 8, 'hC; with fetch_ready=0 → pc_out holds.
- pc_out='h40, redirect_valid=1 target 'h200, exc_req=1 same cycle → pc_out='h100, ras_count=0.
- Push 'h1004, 'h2008; ret_pop → pc_out='h2008, count 1; ret_pop → 'h1004, count 0; ret_pop → ras_underflow=1, pc_out advances by STEP.
- Push 9 addresses 'h10..'h90 (DEPTH 8) → ras_full=1, count 8; 8 pops return 'h90 down to 'h20; 9th pop underflows.
- Count 2 top 'h500, call_push 'h600 with ret_pop → pc_out='h500, count 2, next pop → 'h600.
- WIDTH=64, pc_out='hFFFF_FFFF_FFFF_FFFC, fetch_ready=1 → pc_out=0; assert reset_n low between edges → pc_out=RESET_VEC before next edge.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared defaults and the next-PC source encoding for pc_gen.
//   PC_WIDTH_DEF / PC_STEP_DEF     default PC width and sequential step
//   RESET_VEC_DEF / EXC_VEC_DEF    default reset and exception vectors
//   pc_src_e                       which source feeds the PC register next
package pc_gen_pkg;

    localparam int          PC_WIDTH_DEF  = 64;
    localparam int          PC_STEP_DEF   = 4;
    localparam logic [63:0] RESET_VEC_DEF = 64'h0;
    localparam logic [63:0] EXC_VEC_DEF   = 64'h100;

    typedef enum logic [2:0] {
        SRC_EXC,
        SRC_REDIR,
        SRC_RAS,
        SRC_SEQ,
        SRC_HOLD
    } pc_src_e;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: request/response bundle between the branch/exception logic
// and the PC generator.
//   master: drives fetch_ready, redirect_*, exc_req, call_*, ret_pop
//   slave : drives pc_out and the RAS status outputs
interface pc_gen_if
    import pc_gen_pkg::*;
#(
    parameter int WIDTH     = PC_WIDTH_DEF,
    parameter int RAS_DEPTH = 8
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic             fetch_ready;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             exc_req;
    logic             call_push;
    logic [WIDTH-1:0] call_link;
    logic             ret_pop;
    logic [WIDTH-1:0] pc_out;
    logic [CW-1:0]    ras_count;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_underflow;

    modport master (
        output fetch_ready, redirect_valid, redirect_target, exc_req,
               call_push, call_link, ret_pop,
        input  pc_out, ras_count, ras_empty, ras_full, ras_underflow
    );

    modport slave (
        input  fetch_ready, redirect_valid, redirect_target, exc_req,
               call_push, call_link, ret_pop,
        output pc_out, ras_count, ras_empty, ras_full, ras_underflow
    );

endinterface

// File: rtl/pc_gen_ras_stack.sv
// ras_stack: circular return-address stack (top pointer + count).
//   clk, reset_n   clock, async active-low reset (pointer/count only)
//   i_push, i_link push request and address
//   i_pop          pop request (caller guarantees the stack is non-empty)
//   i_flush        drop all entries; overrides push and pop
//   o_top          entry at the top pointer
//   o_count        number of valid entries
module ras_stack #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_link,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_top,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_count;

    logic             w_wr_en;
    logic [PW-1:0]    w_wr_idx;

    // Push+pop in one cycle replaces the top in place; a lone push writes
    // one slot above the current top (wrapping, so a full stack loses its oldest).
    assign w_wr_en  = i_push & ~i_flush;
    assign w_wr_idx = i_pop ? r_ptr : r_ptr + PW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else if (i_push && !i_pop) begin
            r_ptr <= r_ptr + PW'(1);
            if (r_count != CW'(DEPTH))
                r_count <= r_count + CW'(1);
        end else if (i_pop && !i_push) begin
            r_ptr   <= r_ptr - PW'(1);
            r_count <= r_count - CW'(1);
        end
    end

    // Storage is deliberately not reset; count alone defines validity.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_wr_idx] <= i_link;
    end

    assign o_top   = r_mem[r_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with return-address stack.
//   clk, reset_n   clock, async active-low reset
//   bus (slave)    fetch_ready/redirect/exception/call/return requests in,
//                  pc_out and RAS status out (all registered)
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH_DEF,
    parameter int               STEP      = PC_STEP_DEF,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEF),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VEC_DEF),
    parameter int               RAS_DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    pc_gen_if.slave  bus
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic [WIDTH-1:0] r_pc;
    logic             r_underflow;

    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_ras_top;
    logic [CW-1:0]    w_ras_count;
    logic             w_ras_empty;
    logic             w_pop_req;
    logic             w_pop;
    logic             w_push;
    pc_src_e          w_src;

    // A return only counts when nothing higher-priority redirects this cycle.
    assign w_ras_empty = (w_ras_count == '0);
    assign w_pop_req   = bus.ret_pop & ~bus.exc_req & ~bus.redirect_valid;
    assign w_pop       = w_pop_req & ~w_ras_empty;
    assign w_push      = bus.call_push & ~bus.exc_req;

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_link  (bus.call_link),
        .i_pop   (w_pop),
        .i_flush (bus.exc_req),
        .o_top   (w_ras_top),
        .o_count (w_ras_count)
    );

    always_comb begin
        w_src = SRC_HOLD;
        if (bus.exc_req)
            w_src = SRC_EXC;
        else if (bus.redirect_valid)
            w_src = SRC_REDIR;
        else if (w_pop)
            w_src = SRC_RAS;
        else if (bus.fetch_ready)
            w_src = SRC_SEQ;
    end

    always_comb begin
        w_pc_nxt = r_pc;
        case (w_src)
            SRC_EXC:   w_pc_nxt = EXC_VEC;
            SRC_REDIR: w_pc_nxt = bus.redirect_target;
            SRC_RAS:   w_pc_nxt = w_ras_top;
            SRC_SEQ:   w_pc_nxt = r_pc + WIDTH'(STEP);
            default:   w_pc_nxt = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc        <= RESET_VEC;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_underflow <= w_pop_req & w_ras_empty;
        end
    end

    assign bus.pc_out        = r_pc;
    assign bus.ras_count     = w_ras_count;
    assign bus.ras_empty     = w_ras_empty;
    assign bus.ras_full      = (w_ras_count == CW'(RAS_DEPTH));
    assign bus.ras_underflow = r_underflow;

endmodule
